// File: rtl/frame_queue_if.sv
// Handshake/status bundle between a frame_queue and its serial-handler/console-responder users.
interface frame_queue_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          wr_en;
  logic [31:0]   wr_data;
  logic          rd_en;
  logic [31:0]   rd_data;
  logic          empty;
  logic          full;
  logic [LW-1:0] level;
  logic          next_frame_request;
  logic          overflow;
  logic          underflow;
  logic [31:0]   frames_played;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, empty, full, level, next_frame_request, overflow, underflow, frames_played
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, empty, full, level, next_frame_request, overflow, underflow, frames_played
  );
endinterface

// File: rtl/frame_queue.sv
// Per-console show-ahead FIFO of N64 controller frames with low-water frame request generator.
// Define FRAME_QUEUE_STATS_EN to build the frames_played pop counter.
module frame_queue #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned LOW_WATER   = 4,
  parameter int unsigned REQ_TIMEOUT = 5000000
) (
  input logic         sys_clk,
  input logic         rst_n,
  frame_queue_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned TW = $clog2(REQ_TIMEOUT);
  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);
  localparam logic [LW-1:0] LowWater  = LW'(LOW_WATER);
  localparam logic [TW-1:0] TimerLast = TW'(REQ_TIMEOUT - 1);

  typedef enum logic {StIdle, StWait} req_state_e;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          empty_q, empty_d, full_q, full_d;
  logic          overflow_q, overflow_d, underflow_q, underflow_d;
  logic [31:0]   last_q, last_d;
  req_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          req_q, req_d;
  logic          pop, wr_accept;

  assign pop       = bus.rd_en && !empty_q;
  // A pop in the same cycle frees the slot, so a write into a full queue still lands.
  assign wr_accept = bus.wr_en && (!full_q || bus.rd_en);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    last_d      = last_q;
    state_d     = state_q;
    timer_d     = timer_q;
    req_d       = 1'b0;

    if (wr_accept) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      last_d   = mem_q[rd_ptr_q];
    end
    if (wr_accept && !pop)      level_d = level_q + LW'(1);
    else if (!wr_accept && pop) level_d = level_q - LW'(1);

    if (bus.rd_en && empty_q)               underflow_d = 1'b1;
    if (bus.wr_en && full_q && !bus.rd_en)  overflow_d  = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (level_d < LowWater) begin
          req_d   = 1'b1;
          timer_d = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        timer_d = timer_q + TW'(1);
        if (wr_accept || timer_q == TimerLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      last_d      = '0;
      state_d     = StIdle;
      timer_d     = '0;
      req_d       = 1'b0;
    end

    empty_d = (level_d == '0);
    full_d  = (level_d == LevelFull);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      last_q      <= '0;
      state_q     <= StIdle;
      timer_q     <= '0;
      req_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      last_q      <= last_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      req_q       <= req_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever visible.
  always_ff @(posedge sys_clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  // While empty, keep presenting the last popped frame so the console repeats its input.
  assign bus.rd_data            = empty_q ? last_q : mem_q[rd_ptr_q];
  assign bus.empty              = empty_q;
  assign bus.full               = full_q;
  assign bus.level              = level_q;
  assign bus.next_frame_request = req_q;
  assign bus.overflow           = overflow_q;
  assign bus.underflow          = underflow_q;

`ifdef FRAME_QUEUE_STATS_EN
  logic [31:0] played_q, played_d;

  always_comb begin
    played_d = played_q;
    if (pop)       played_d = played_q + 32'd1;
    if (bus.flush) played_d = '0;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) played_q <= '0;
    else        played_q <= played_d;
  end

  assign bus.frames_played = played_q;
`else
  assign bus.frames_played = 32'h0;
`endif
endmodule

// File: tb/tb_frame_queue.sv
// Self-checking bench for frame_queue: queue-based reference model plus directed literal checks.
module tb_frame_queue;
  localparam int unsigned DEPTH       = 16;
  localparam int unsigned LOW_WATER   = 4;
  localparam int unsigned REQ_TIMEOUT = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  frame_queue_if #(.DEPTH(DEPTH)) bus ();

  frame_queue #(
    .DEPTH      (DEPTH),
    .LOW_WATER  (LOW_WATER),
    .REQ_TIMEOUT(REQ_TIMEOUT)
  ) dut (
    .sys_clk(clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mq[$];
  logic [31:0] m_last;
  logic [31:0] m_played;
  bit          m_of, m_uf, m_req, m_idle;
  int          m_edge, m_req_edge;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_last   = 32'h0;
    m_played = 32'h0;
    m_of     = 1'b0;
    m_uf     = 1'b0;
    m_req    = 1'b0;
    m_idle   = 1'b1;
  endtask

  task automatic m_step();
    bit wr, rd, was_full, was_empty, do_pop, do_wr;
    wr        = bus.wr_en;
    rd        = bus.rd_en;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    do_pop    = rd && !was_empty;
    do_wr     = wr && (!was_full || rd);
    if (rd && was_empty)          m_uf = 1'b1;
    if (wr && was_full && !rd)    m_of = 1'b1;
    if (do_pop) begin
      m_last = mq.pop_front();
`ifdef FRAME_QUEUE_STATS_EN
      m_played = m_played + 32'd1;
`endif
    end
    if (do_wr) mq.push_back(bus.wr_data);
    m_edge++;
    // Request rules: fire when idle and low; leave waiting on a write or REQ_TIMEOUT edges later.
    if (m_idle) begin
      m_req = (mq.size() < LOW_WATER);
      if (m_req) begin
        m_idle     = 1'b0;
        m_req_edge = m_edge;
      end
    end else begin
      m_req = 1'b0;
      if (do_wr || (m_edge - m_req_edge == REQ_TIMEOUT)) m_idle = 1'b1;
    end
  endtask

  initial begin
    m_edge     = 0;
    m_req_edge = 0;
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || bus.flush) m_reset();
      else                     m_step();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("rd_data", bus.rd_data, (mq.size() > 0) ? mq[0] : m_last);
      chk("level", 32'(bus.level), 32'(mq.size()));
      chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
      chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
      chk("overflow", 32'(bus.overflow), 32'(m_of));
      chk("underflow", 32'(bus.underflow), 32'(m_uf));
      chk("next_frame_request", 32'(bus.next_frame_request), 32'(m_req));
      chk("frames_played", bus.frames_played, m_played);
    end
  end

  task automatic cyc(input logic w, input logic [31:0] d, input logic r);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  task automatic count_req(input int n, output int cnt, output int first);
    cnt   = 0;
    first = -1;
    for (int i = 1; i <= n; i++) begin
      if (i > 1) @(negedge clk);
      if (bus.next_frame_request) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
  endtask

  initial begin
    int cnt, first;
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 32'h0;
    bus.rd_en   = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_empty", 32'(bus.empty), 32'd1);
    chk("reset_rd_data", bus.rd_data, 32'h0);
    chk("reset_level", 32'(bus.level), 32'd0);
    chk("reset_req", 32'(bus.next_frame_request), 32'd0);
    rst_n = 1'b1;

    // Requests at edge 1, then every REQ_TIMEOUT+1 edges: 1, 22, 43
    @(negedge clk);
    count_req(45, cnt, first);
    chk("timeout_req_count", 32'(cnt), 32'd3);
    chk("first_req_cycle", 32'(first), 32'd1);

    // Fill, overflow, drain in order
    do_flush();
    for (int i = 1; i <= 16; i++) cyc(1'b1, 32'(i), 1'b0);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_level", 32'(bus.level), 32'd16);
    cyc(1'b1, 32'hDEADBEEF, 1'b0);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_level", 32'(bus.level), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_order", bus.rd_data, 32'(i));
      cyc(1'b0, 32'h0, 1'b1);
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // Underflow holds last popped frame
    do_flush();
    cyc(1'b1, 32'h12345678, 1'b0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("pre_underflow", 32'(bus.underflow), 32'd0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("underflow_flag", 32'(bus.underflow), 32'd1);
    chk("underflow_hold", bus.rd_data, 32'h12345678);
    chk("underflow_level", 32'(bus.level), 32'd0);

    // Low-water crossing: one pulse, then a write re-arms without a new pulse at level 4
    do_flush();
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0);
    count_req(5, cnt, first);
    chk("lw_idle_no_req", 32'(cnt), 32'd0);
    @(negedge clk);
    cyc(1'b0, 32'h0, 1'b1);
    count_req(10, cnt, first);
    chk("lw_one_req", 32'(cnt), 32'd1);
    @(negedge clk);
    cyc(1'b1, 32'h200, 1'b0);
    count_req(10, cnt, first);
    chk("lw_after_write", 32'(cnt), 32'd0);
    chk("lw_level", 32'(bus.level), 32'd4);

    // Simultaneous write+pop while full
    do_flush();
    for (int i = 1; i <= 16; i++) cyc(1'b1, 32'd100 + 32'(i), 1'b0);
    cyc(1'b1, 32'hAAAA5555, 1'b1);
    chk("full_wr_rd_level", 32'(bus.level), 32'd16);
    chk("full_wr_rd_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 32'h0, 1'b1);
    chk("full_wr_rd_last", bus.rd_data, 32'hAAAA5555);
    cyc(1'b0, 32'h0, 1'b1);
    chk("full_wr_rd_empty", 32'(bus.empty), 32'd1);

    // Simultaneous write+pop while empty
    do_flush();
    cyc(1'b1, 32'h0BADF00D, 1'b1);
    chk("empty_wr_rd_level", 32'(bus.level), 32'd1);
    chk("empty_wr_rd_uf", 32'(bus.underflow), 32'd1);
    chk("empty_wr_rd_data", bus.rd_data, 32'h0BADF00D);

    // Pop counter: 5 good pops + 2 underflows
    do_flush();
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h300 + 32'(i), 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 32'h0, 1'b1);
`ifdef FRAME_QUEUE_STATS_EN
    chk("frames_played", bus.frames_played, 32'd5);
`else
    chk("frames_played", bus.frames_played, 32'd0);
`endif
    do_flush();
    chk("frames_played_flush", bus.frames_played, 32'd0);
    chk("flush_empty", 32'(bus.empty), 32'd1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frame_queue.md
Name: frame_queue

Overview:
- Per-console FIFO of 32-bit N64 controller frames, one instance per console.
- Upstream: the serial handler writes frames in via queue write-enable and data.
- Downstream: the n64_controller console-side responder pops one frame per console poll.
- Issues the single-cycle next-frame request pulse back to the serial handler when its fill level runs low. Re-requests on timeout if the host does not respond.

Parameters:
- DEPTH, 16, number of frame entries; power of two, min 4.
- LOW_WATER, 4, request more frames when level drops below this; 1..DEPTH-1.
- REQ_TIMEOUT, 5000000, sys_clk cycles (100 ms at 50 MHz) to wait for a write after a request before re-requesting; min 2.

Ports:
- sys_clk  input  1  50 MHz system clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear; driven by n64_controller_reset.
- wr_en  input  1  write strobe from serial handler (queue_WrEn).
- wr_data  input  32  frame to enqueue.
- rd_en  input  1  pop strobe from console responder; one per poll.
- rd_data  output  32  current frame (show-ahead).
- empty  output  1  no frames stored.
- full  output  1  DEPTH frames stored.
- level  output  $clog2(DEPTH)+1  frames stored.
- next_frame_request  output  1  one-cycle request pulse to serial handler.
- overflow  output  1  sticky: write dropped while full.
- underflow  output  1  sticky: pop attempted while empty.
- frames_played  output  32  frames popped since reset/flush (see Optional Feature).

Behaviour:
- Reset (rst_n=0, async):
  - pointers=0, level=0, empty=1, full=0.
  - rd_data=32'h0 (neutral controller), next_frame_request=0.
  - overflow=0, underflow=0, frames_played=0.
  - request FSM in IDLE, timeout counter=0.
- flush=1: same state as reset, applied on the next sys_clk edge. flush has priority over wr_en/rd_en in that cycle.
- Show-ahead read:
  - When !empty, rd_data = entry at the read pointer, combinational from storage or registered with zero visible latency.
  - rd_en with !empty pops that entry. The next entry appears in the following cycle.
- Underflow:
  - rd_en with empty: no pop; underflow set (sticky).
  - rd_data holds the last frame popped, so the console repeats the previous input. After reset/flush this value is 0.
- Write:
  - wr_en with !full stores wr_data at the write pointer; the pointer increments.
  - wr_en with full and no pop: data dropped, overflow set (sticky).
- Simultaneous events:
  - wr_en and rd_en while full: both succeed, level unchanged.
  - wr_en and rd_en while empty: write stored, read counts as underflow, level becomes 1.
  - Otherwise both proceed and level is unchanged.
- Pointers wrap modulo DEPTH. level = count register, never computed from pointers alone.
- Flags: full = (level==DEPTH); empty = (level==0). Both are registered and consistent with level in the same cycle.
- Request FSM, evaluated every cycle on the post-update level:
  - IDLE: if level < LOW_WATER, assert next_frame_request for exactly 1 cycle, clear timer, go to WAIT.
  - WAIT: timer increments each cycle.
    - Any accepted write returns the FSM to IDLE. IDLE may re-request next cycle if level is still low; this gives one request per received frame.
    - timer == REQ_TIMEOUT-1: go to IDLE (re-request next evaluation).
  - next_frame_request is never high on two consecutive cycles.
  - After reset/flush the FSM starts in IDLE, so a request fires the first cycle after reset/flush releases.

Optional Feature:
- Macro: FRAME_QUEUE_STATS_EN.
- Defined: frames_played is a 32-bit counter incremented on each successful pop (not on underflow). It wraps 32'hFFFFFFFF -> 0 and is cleared by reset/flush.
- Undefined: frames_played is tied to 32'h0 and no counter logic is synthesised; all other behaviour is identical.

Test Plan:
- Reset release with no writes -> next_frame_request pulses 1 cycle at first edge, again after REQ_TIMEOUT cycles; empty=1, rd_data=0.
- Write 16 frames 0x00000001..0x00000010 (DEPTH=16) -> full=1, level=16. A 17th write 0xDEADBEEF is dropped and overflow=1. Then 16 pops return 1..16 in order, and empty=1 after the last pop.
- Pop on empty after popping 0x12345678 -> underflow=1, rd_data stays 0x12345678, level stays 0.
- Level 4 -> pop to 3 -> exactly one next_frame_request pulse. A write returns the FSM to IDLE; with level at 4 after that write, no further pulse.
- Full with simultaneous wr_en(0xAAAA5555)+rd_en -> level stays 16, no overflow, 0xAAAA5555 is read last. Empty with simultaneous wr+rd -> level=1, underflow=1.
- With FRAME_QUEUE_STATS_EN: 5 pops + 2 underflow pops -> frames_played=5; flush -> 0. Without the macro -> frames_played always 0.
